// File: rtl/memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : memory_arbiter
// Purpose  : Shares one single-ported system RAM between the instruction-fetch
//            port and the data (load/store) port. One grant at a time; the
//            granted address, store data and strobes are captured on grant
//            entry and held until RAM reports ready or the watchdog aborts.
//            On simultaneous requests the data port wins unless it won the
//            previous grant, so neither port can be starved.
// Ports    : CLK, nRST (sync, active-low)
//            iREN/iaddr -> iload/iwait        instruction port
//            dREN/dWEN/daddr/dstore -> dload/dwait   data port
//            ramREN/ramWEN/ramaddr/ramstore <- ramload/ramready   RAM side
//            merr : one-cycle pulse when the watchdog aborts a grant
// Params   : TIMEOUT (2..255) cycles a grant may wait for ramready
// Revision : 1.0 - initial release
// ============================================================================
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        merr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    INST = 2'd2
  } state_t;

  // Watchdog fires in the cycle where the counter reaches TIMEOUT-1.
  localparam logic [7:0] C_WDOG_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic        ramREN_q;
  logic        ramWEN_q;
  logic [31:0] ramaddr_q;
  logic [31:0] ramstore_q;
  logic [7:0]  wcnt_q;
  logic        last_data_q;   // 1: previous grant went to the data port

  logic w_dreq;
  logic w_busy;
  logic w_expired;
  logic w_done;
  logic w_data_done;
  logic w_inst_done;

  assign w_dreq    = dREN | dWEN;
  assign w_busy    = (state_q != IDLE);
  assign w_expired = w_busy && (wcnt_q == C_WDOG_LAST);
  // A ramready in the expiry cycle is a normal completion.
  assign w_done    = w_busy && (ramready || w_expired);

  assign w_data_done = (state_q == DATA) && w_done;
  assign w_inst_done = (state_q == INST) && w_done;

  assign merr  = w_expired & ~ramready;
  assign iwait = iREN & ~w_inst_done;
  assign dwait = w_dreq & ~w_data_done;

  // Read data passes through only on a real completion; an abort returns 0.
  assign iload = ((state_q == INST) && ramready) ? ramload : 32'd0;
  assign dload = ((state_q == DATA) && ramready) ? ramload : 32'd0;

  assign ramREN   = ramREN_q;
  assign ramWEN   = ramWEN_q;
  assign ramaddr  = ramaddr_q;
  assign ramstore = ramstore_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      ramREN_q    <= 1'b0;
      ramWEN_q    <= 1'b0;
      ramaddr_q   <= 32'd0;
      ramstore_q  <= 32'd0;
      wcnt_q      <= 8'd0;
      last_data_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (w_dreq && (!iREN || !last_data_q)) begin
            state_q    <= DATA;
            ramaddr_q  <= daddr;
            ramstore_q <= dstore;
            // A store request overrides a simultaneous load request.
            ramWEN_q   <= dWEN;
            ramREN_q   <= ~dWEN;
            wcnt_q     <= 8'd0;
          end else if (iREN) begin
            state_q   <= INST;
            ramaddr_q <= iaddr;
            ramREN_q  <= 1'b1;
            ramWEN_q  <= 1'b0;
            wcnt_q    <= 8'd0;
          end
        end
        DATA, INST: begin
          // The grant runs to completion even if the requester has gone away.
          if (w_done) begin
            state_q     <= IDLE;
            ramREN_q    <= 1'b0;
            ramWEN_q    <= 1'b0;
            last_data_q <= (state_q == DATA);
          end else begin
            wcnt_q <= wcnt_q + 8'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          ramREN_q <= 1'b0;
          ramWEN_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_memory_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_arbiter
// Purpose  : Self-checking bench for memory_arbiter. A transaction-level
//            reference (owner / age / captured request) predicts every output
//            each cycle; directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_arbiter;

  localparam int TO = 15;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        merr;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .merr(merr)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  // Reference: owner 0 = none, 1 = data, 2 = instruction; age = cycles in grant.
  int          m_owner;
  int          m_age;
  logic [31:0] m_addr;
  logic [31:0] m_store;
  bit          m_wr;
  bit          m_last_data;

  // Values seen at the most recent check point.
  logic        obs_on;
  logic        obs_merr;
  logic [31:0] obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner     = 0;
    m_age       = 0;
    m_addr      = 32'd0;
    m_store     = 32'd0;
    m_wr        = 1'b0;
    m_last_data = 1'b0;
  endtask

  // Called just after a rising edge with inputs already applied; checks the
  // cycle, advances the reference across the next edge, returns after it.
  task automatic step(input string tag);
    bit dreq, ex, fin, e_ren, e_wen;
    #1;
    dreq  = (dREN | dWEN);
    ex    = (m_owner != 0) && (m_age == TO - 1);
    fin   = (m_owner != 0) && (ramready || ex);
    e_ren = (m_owner == 2) || (m_owner == 1 && !m_wr);
    e_wen = (m_owner == 1) && m_wr;
    obs_on   = ramREN | ramWEN;
    obs_merr = merr;
    obs_addr = ramaddr;
    chk({tag, ":ramREN"},   32'(ramREN), 32'(e_ren));
    chk({tag, ":ramWEN"},   32'(ramWEN), 32'(e_wen));
    chk({tag, ":ramaddr"},  ramaddr, m_addr);
    chk({tag, ":ramstore"}, ramstore, m_store);
    chk({tag, ":merr"},     32'(merr), 32'(ex && !ramready));
    chk({tag, ":iwait"},    32'(iwait), 32'(iREN && !(m_owner == 2 && fin)));
    chk({tag, ":dwait"},    32'(dwait), 32'(dreq && !(m_owner == 1 && fin)));
    chk({tag, ":iload"},    iload, (m_owner == 2 && ramready) ? ramload : 32'd0);
    chk({tag, ":dload"},    dload, (m_owner == 1 && ramready) ? ramload : 32'd0);
    if (!nRST) begin
      model_reset();
    end else if (m_owner != 0) begin
      if (fin) begin
        m_last_data = (m_owner == 1);
        m_owner     = 0;
      end else begin
        m_age++;
      end
    end else if (dreq && (!iREN || !m_last_data)) begin
      m_owner = 1; m_age = 0; m_addr = daddr; m_store = dstore; m_wr = dWEN;
    end else if (iREN) begin
      m_owner = 2; m_age = 0; m_addr = iaddr;
    end
    @(posedge CLK);
    #1;
    ramload = $urandom;
  endtask

  task automatic idle_inputs();
    iREN = 0; dREN = 0; dWEN = 0; ramready = 0;
  endtask

  initial begin
    logic [31:0] order [4];
    int          n_got;
    bit          prev_on;
    int          merr_cnt;
    int          merr_at;

    nRST = 0; idle_inputs();
    iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    @(posedge CLK); #1;
    model_reset();
    step("reset0");
    step("reset1");
    nRST = 1;
    step("idle");

    // Single instruction read, ready three cycles after the request.
    iREN = 1; iaddr = 32'h40;
    step("rd_N");
    step("rd_N1");
    step("rd_N2");
    ramready = 1; ramload = 32'h8C010004;
    step("rd_N3");
    idle_inputs();
    step("rd_done");

    // Contention from reset: grants must alternate DATA, INST, DATA, INST.
    nRST = 0;
    step("ct_rst");
    nRST = 1;
    iREN = 1; dREN = 1; iaddr = 32'h300; daddr = 32'h200;
    order = '{default: 32'd0};
    n_got = 0; prev_on = 0;
    for (int k = 0; k < 24; k++) begin
      ramready = (m_owner != 0) && (m_age == 2);
      step("contend");
      if (obs_on && !prev_on && n_got < 4) begin
        order[n_got] = obs_addr;
        n_got++;
      end
      prev_on = obs_on;
    end
    idle_inputs();
    step("ct_end");
    chk("ct_order0", order[0], 32'h200);
    chk("ct_order1", order[1], 32'h300);
    chk("ct_order2", order[2], 32'h200);
    chk("ct_order3", order[3], 32'h300);
    step("ct_drain");

    // Store wins over a load; address/data held while daddr toggles.
    dREN = 1; dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    step("st_arb");
    for (int k = 0; k < 4; k++) begin
      daddr  = daddr ^ 32'hFFFF_0F0F;
      dstore = ~dstore;
      step("st_hold");
      chk("st_addr", obs_addr, 32'h100);
      chk("st_store", ramstore, 32'hDEADBEEF);
    end
    ramready = 1;
    step("st_done");
    idle_inputs();
    step("st_idle");

    // Watchdog abort: no ramready at all.
    dREN = 1; daddr = 32'h600; merr_cnt = 0; merr_at = -1;
    for (int k = 0; k < 20; k++) begin
      step("wd");
      if (obs_merr) begin merr_cnt++; merr_at = k; end
      if (k == TO) dREN = 0;
    end
    chk("wd_merr_count", 32'(merr_cnt), 32'd1);
    chk("wd_merr_cycle", 32'(merr_at), 32'(TO));

    // Watchdog race: ramready in the expiry cycle completes normally.
    dREN = 1; merr_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      ramready = (k == TO);
      step("wd_race");
      if (obs_merr) merr_cnt++;
      if (k == TO) dREN = 0;
    end
    ramready = 0;
    chk("wd_race_merr", 32'(merr_cnt), 32'd0);

    // Flush: iREN withdrawn mid-grant, grant still finishes.
    iREN = 1; iaddr = 32'h880;
    step("fl_arb");
    step("fl_g0");
    iREN = 0;
    step("fl_g1");
    step("fl_g2");
    ramready = 1;
    step("fl_done");
    ramready = 0;
    step("fl_idle");

    // Reset during a data grant; later ramready is ignored.
    dREN = 1; daddr = 32'h500; dstore = 32'h1234;
    step("rm_arb");
    step("rm_g0");
    nRST = 0; dREN = 0;
    step("rm_rst");
    nRST = 1; ramready = 1;
    step("rm_late");
    ramready = 0;
    step("rm_idle");

    // Random traffic: mostly-responsive RAM, then a sluggish one.
    for (int k = 0; k < 900; k++) begin
      nRST     = ($urandom_range(99) >= 2);
      iREN     = $urandom_range(1);
      dREN     = $urandom_range(1);
      dWEN     = ($urandom_range(3) == 0);
      iaddr    = $urandom;
      daddr    = $urandom;
      dstore   = $urandom;
      ramready = (k < 600) ? ($urandom_range(99) < 40) : ($urandom_range(99) < 3);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
